even_parity_checker: RTL and testbench
======================================

// Module: even_parity_checker
// PURPOSE
//  Even-parity checker and generator for one data word plus its parity bit. The datapath is registered.
//  Each cycle with in_valid=1, the block flags an error when the total count of 1s in {data1,parity_bit} is odd.
//  In the same cycle it also outputs the even-parity bit that data1 needs.
//  Sits at the receive side of a byte link; its error/statistics outputs feed status registers.
// PARAMETERS
//  DATA_W  8   width of data1 in bits (>=1)
//  CNT_W   16  width of err_count and chk_count (>=2)
// PORTS
//  clk         in   1       single clock; all state updates on posedge clk
//  rst         in   1       synchronous, active-high reset
//  in_valid    in   1       data1/parity_bit qualify this cycle
//  data1       in   DATA_W  data word under check
//  parity_bit  in   1       received parity bit (even parity)
//  clr_stats   in   1       synchronous clear of counters and sticky flag
//  out_valid   out  1       error/gen_parity valid (in_valid delayed 1 cycle)
//  error       out  1       1 = parity violation on the word accepted last cycle
//  gen_parity  out  1       even-parity bit for data1 accepted last cycle (= ^data1)
//  err_sticky  out  1       set by any error, held until rst/clr_stats
//  err_count   out  CNT_W   number of errored words, saturating
//  chk_count   out  CNT_W   number of words checked, saturating
// BEHAVIOUR
//  - Clock and reset: one clock, clk. Reset rst is synchronous and active-high; while rst=1 at posedge,
//    every output register goes to 0: out_valid, error, gen_parity, err_sticky, err_count, chk_count.
//    in_valid is ignored in that cycle. rst takes priority over clr_stats and in_valid.
//  - Combinational terms: p = ^data1; e = p ^ parity_bit.
//    e = 1 when popcount(data1)+parity_bit is odd.
//  - Latency 1: at posedge with in_valid=1:
//    out_valid<=1, gen_parity<=p, error<=e.
//  - At posedge with in_valid=0:
//    out_valid<=0, error<=0, gen_parity holds its last value.
//  - error is a single-cycle pulse per errored word. There is no back-pressure; a new word may arrive every cycle.
//  - chk_count increments by 1 per accepted word and saturates at 2^CNT_W-1 (no wrap).
//  - err_count increments by 1 per accepted word with e=1 and saturates at 2^CNT_W-1 (no wrap).
//  - err_sticky <= 1 on any accepted word with e=1.
//  - clr_stats=1 (rst=0): err_count, chk_count and err_sticky are loaded as follows:
//    - err_count/chk_count get the contribution of the current word only: 0 or 1 each.
//    - err_sticky <= e&in_valid.
//    - So the word accepted with clr_stats is counted after the clear.
//    - out_valid/error/gen_parity are unaffected by clr_stats.
//  - X/Z on data1 is not a supported case; the inputs are assumed to be fully driven when in_valid=1.
//  - No internal FSM. State is only the output registers and the two counters.
// TESTING
//  1 rst=1 for 2 cycles, in_valid=1 -> all outputs 0 after reset; counters 0.
//  2 DATA_W=8, in_valid=1, one vector per cycle:
//    - 00111100/p=1 -> error=1, gen_parity=0
//    - 00011100/p=0 -> error=1, gen_parity=1
//    - 00111101/p=1 -> error=0, gen_parity=1
//    - 01001100/p=1 -> error=0, gen_parity=1
//    - each result appears one cycle later with out_valid=1.
//  3 After test 2: err_count=2, chk_count=4, err_sticky=1.
//    Then clr_stats=1, in_valid=0 -> err_count=0, chk_count=0, err_sticky=0.
//  4 00000000/p=0 and 11111111/p=0 -> error=0; 00000001/p=0 -> error=1.
//    With in_valid=0 between words, out_valid=0 and error=0 in those gap cycles.
//  5 CNT_W=2: send 5 errored words back-to-back -> err_count saturates at 3, chk_count=3, no wrap to 0.
//  6 Assert rst mid-stream, in the cycle after an errored word:
//    - next cycle error=0, out_valid=0, counters 0, err_sticky=0.
//    - then resume checking normally.

Source files
------------

// File: rtl/even_parity_checker.sv
// rtl/even_parity_checker.sv - registered even-parity checker/generator with error statistics
//
// Checks one data word plus its received even-parity bit per accepted cycle,
// reports the result one cycle later, and keeps saturating word/error counters
// and a sticky error flag for status registers.
//
// Ports:
//   clk         single clock, all state on posedge
//   rst         synchronous active-high reset (highest priority)
//   in_valid    data1/parity_bit qualify this cycle
//   data1       data word under check
//   parity_bit  received even-parity bit
//   clr_stats   synchronous clear of counters and sticky flag
//   out_valid   in_valid delayed one cycle
//   error       one-cycle pulse: parity violation on last accepted word
//   gen_parity  even-parity bit of last accepted word (holds between words)
//   err_sticky  set by any error, held until rst/clr_stats
//   err_count   saturating count of errored words
//   chk_count   saturating count of checked words

module even_parity_checker #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] data1,
   input  logic              parity_bit,
   input  logic              clr_stats,
   output logic              out_valid,
   output logic              error,
   output logic              gen_parity,
   output logic              err_sticky,
   output logic [CNT_W-1:0]  err_count,
   output logic [CNT_W-1:0]  chk_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic p;
   logic e;
   logic acc_word;
   logic acc_err;

   assign p        = ^data1;
   assign e        = p ^ parity_bit;
   assign acc_word = in_valid;
   assign acc_err  = in_valid & e;

   // Result pipeline stage
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         error      <= 1'b0;
         gen_parity <= 1'b0;
      end else if (in_valid) begin
         out_valid  <= 1'b1;
         error      <= e;
         gen_parity <= p;
      end else begin
         out_valid  <= 1'b0;
         error      <= 1'b0;
      end
   end

   // Statistics: on clr_stats the current word still counts, so the counters
   // reload with this cycle's contribution instead of zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_sticky <= 1'b0;
         err_count  <= '0;
         chk_count  <= '0;
      end else if (clr_stats) begin
         err_sticky <= acc_err;
         err_count  <= acc_err  ? CNT_ONE : '0;
         chk_count  <= acc_word ? CNT_ONE : '0;
      end else begin
         if (acc_err) begin
            err_sticky <= 1'b1;
         end
         if (acc_err && (err_count != CNT_MAX)) begin
            err_count <= err_count + CNT_ONE;
         end
         if (acc_word && (chk_count != CNT_MAX)) begin
            chk_count <= chk_count + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_even_parity_checker.sv
// tb/tb_even_parity_checker.sv - self-checking bench for even_parity_checker
module tb_even_parity_checker;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] data1;
   logic       parity_bit;
   logic       clr_stats;

   logic        ov_a, err_a, gp_a, st_a;
   logic [15:0] ec_a, cc_a;
   logic        ov_b, err_b, gp_b, st_b;
   logic [1:0]  ec_b, cc_b;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   even_parity_checker #(.DATA_W(8), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .data1(data1),
      .parity_bit(parity_bit), .clr_stats(clr_stats),
      .out_valid(ov_a), .error(err_a), .gen_parity(gp_a),
      .err_sticky(st_a), .err_count(ec_a), .chk_count(cc_a)
   );

   even_parity_checker #(.DATA_W(8), .CNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .data1(data1),
      .parity_bit(parity_bit), .clr_stats(clr_stats),
      .out_valid(ov_b), .error(err_b), .gen_parity(gp_b),
      .err_sticky(st_b), .err_count(ec_b), .chk_count(cc_b)
   );

   // Behavioural model: parity from the count of ones, counters as plain ints
   logic started = 1'b0;
   logic m_ov, m_err, m_gp, m_st;
   int   m_ec_a, m_cc_a, m_ec_b, m_cc_b;

   function automatic int sat_add(input int v, input int inc, input int maxv);
      return (v + inc > maxv) ? maxv : v + inc;
   endfunction

   function automatic int word_err(input logic [7:0] d, input logic pb);
      return (($countones(d) + int'(pb)) % 2 == 1) ? 1 : 0;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         started <= 1'b1;
         m_ov <= 1'b0; m_err <= 1'b0; m_gp <= 1'b0; m_st <= 1'b0;
         m_ec_a <= 0; m_cc_a <= 0; m_ec_b <= 0; m_cc_b <= 0;
      end else begin
         if (in_valid) begin
            m_ov  <= 1'b1;
            m_err <= word_err(data1, parity_bit) == 1;
            m_gp  <= ($countones(data1) % 2) == 1;
         end else begin
            m_ov  <= 1'b0;
            m_err <= 1'b0;
         end
         if (clr_stats) begin
            m_st   <= in_valid && word_err(data1, parity_bit) == 1;
            m_cc_a <= int'(in_valid);
            m_cc_b <= int'(in_valid);
            m_ec_a <= in_valid ? word_err(data1, parity_bit) : 0;
            m_ec_b <= in_valid ? word_err(data1, parity_bit) : 0;
         end else begin
            if (in_valid && word_err(data1, parity_bit) == 1) m_st <= 1'b1;
            m_cc_a <= sat_add(m_cc_a, int'(in_valid), 65535);
            m_cc_b <= sat_add(m_cc_b, int'(in_valid), 3);
            m_ec_a <= sat_add(m_ec_a, in_valid ? word_err(data1, parity_bit) : 0, 65535);
            m_ec_b <= sat_add(m_ec_b, in_valid ? word_err(data1, parity_bit) : 0, 3);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (started) begin
         chk("a.out_valid",  32'(ov_a),  32'(m_ov));
         chk("a.error",      32'(err_a), 32'(m_err));
         chk("a.gen_parity", 32'(gp_a),  32'(m_gp));
         chk("a.err_sticky", 32'(st_a),  32'(m_st));
         chk("a.err_count",  32'(ec_a),  32'(m_ec_a));
         chk("a.chk_count",  32'(cc_a),  32'(m_cc_a));
         chk("b.out_valid",  32'(ov_b),  32'(m_ov));
         chk("b.error",      32'(err_b), 32'(m_err));
         chk("b.gen_parity", 32'(gp_b),  32'(m_gp));
         chk("b.err_sticky", 32'(st_b),  32'(m_st));
         chk("b.err_count",  32'(ec_b),  32'(m_ec_b));
         chk("b.chk_count",  32'(cc_b),  32'(m_cc_b));
      end
   end

   // Apply one cycle of inputs (called at a negedge, returns at the next one)
   task automatic cyc(input logic r, input logic v, input logic [7:0] d,
                      input logic pb, input logic clr);
      rst = r; in_valid = v; data1 = d; parity_bit = pb; clr_stats = clr;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b1; data1 = 8'hA5; parity_bit = 1'b1; clr_stats = 1'b0;
      @(negedge clk);
      // Reset for two cycles with in_valid high
      cyc(1, 1, 8'h3C, 1, 0);
      cyc(1, 1, 8'h1C, 0, 0);
      chk("rst.out_valid", 32'(ov_a), 0);
      chk("rst.error", 32'(err_a), 0);
      chk("rst.err_count", 32'(ec_a), 0);
      chk("rst.chk_count", 32'(cc_a), 0);

      // Known vectors
      cyc(0, 1, 8'b00111100, 1, 0);
      chk("v0.error", 32'(err_a), 1); chk("v0.gen_parity", 32'(gp_a), 0);
      chk("v0.out_valid", 32'(ov_a), 1);
      cyc(0, 1, 8'b00011100, 0, 0);
      chk("v1.error", 32'(err_a), 1); chk("v1.gen_parity", 32'(gp_a), 1);
      cyc(0, 1, 8'b00111101, 1, 0);
      chk("v2.error", 32'(err_a), 0); chk("v2.gen_parity", 32'(gp_a), 1);
      cyc(0, 1, 8'b01001100, 1, 0);
      chk("v3.error", 32'(err_a), 0); chk("v3.gen_parity", 32'(gp_a), 1);
      cyc(0, 0, 8'h00, 0, 0);
      chk("stats.err_count", 32'(ec_a), 2);
      chk("stats.chk_count", 32'(cc_a), 4);
      chk("stats.err_sticky", 32'(st_a), 1);
      cyc(0, 0, 8'h00, 0, 1);
      chk("clr.err_count", 32'(ec_a), 0);
      chk("clr.chk_count", 32'(cc_a), 0);
      chk("clr.err_sticky", 32'(st_a), 0);

      // Edge patterns with gaps
      cyc(0, 1, 8'h00, 0, 0);
      chk("zero.error", 32'(err_a), 0);
      cyc(0, 0, 8'h55, 1, 0);
      chk("gap1.out_valid", 32'(ov_a), 0); chk("gap1.error", 32'(err_a), 0);
      cyc(0, 1, 8'hFF, 0, 0);
      chk("ones.error", 32'(err_a), 0);
      cyc(0, 0, 8'h55, 1, 0);
      chk("gap2.out_valid", 32'(ov_a), 0); chk("gap2.error", 32'(err_a), 0);
      cyc(0, 1, 8'h01, 0, 0);
      chk("one_bit.error", 32'(err_a), 1);

      // Saturation on the 2-bit instance
      cyc(0, 0, 8'h00, 0, 1);
      for (int i = 0; i < 5; i++) cyc(0, 1, 8'h01, 0, 0);
      cyc(0, 0, 8'h00, 0, 0);
      chk("sat.b.err_count", 32'(ec_b), 3);
      chk("sat.b.chk_count", 32'(cc_b), 3);
      chk("sat.a.err_count", 32'(ec_a), 5);

      // Reset the cycle after an errored word, then resume
      cyc(0, 1, 8'h07, 0, 0);
      cyc(1, 1, 8'h03, 1, 0);
      chk("mid.error", 32'(err_a), 0);
      chk("mid.out_valid", 32'(ov_a), 0);
      chk("mid.err_count", 32'(ec_a), 0);
      chk("mid.chk_count", 32'(cc_a), 0);
      chk("mid.err_sticky", 32'(st_a), 0);
      cyc(0, 1, 8'h03, 1, 0);
      chk("resume.error", 32'(err_a), 1);
      chk("resume.chk_count", 32'(cc_a), 1);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 70),
             8'($urandom), 1'($urandom), ($urandom_range(0, 99) < 5));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
